// File: rtl/camo_key_loader.sv
// Key loader and vector sequencer for the camouflaged c432 netlist: loads a
// parity-checked select key serially, then runs PI vectors and returns the POs.
module camo_key_loader #(
    parameter int unsigned NUM_CELLS     = 6,
    parameter int unsigned KEY_W         = 12,
    parameter int unsigned PI_W          = 36,
    parameter int unsigned PO_W          = 7,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            key_bit,
    input  logic            key_valid,
    output logic            key_ready,
    output logic            key_locked,
    output logic            key_err,
    output logic [KEY_W-1:0] s_out,
    input  logic [PI_W-1:0] vec_in,
    input  logic            vec_valid,
    output logic            vec_ready,
    output logic [PI_W-1:0] pi_out,
    input  logic [PO_W-1:0] po_in,
    output logic [PO_W-1:0] res_out,
    output logic            res_valid,
    input  logic            res_ready
);

    localparam int unsigned CNT_W = $clog2(KEY_W + 2);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(KEY_W + 1);
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        LOAD,
        CHECK,
        READY,
        SETTLE,
        HOLD
    } state_e;

    state_e            state_q, state_d;
    logic [KEY_W:0]    shadow_q, shadow_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [KEY_W-1:0]  s_q, s_d;
    logic              locked_q, locked_d;
    logic              err_q, err_d;
    logic [PI_W-1:0]   pi_q, pi_d;
    logic [7:0]        settle_q, settle_d;
    logic [PO_W-1:0]   res_q, res_d;
    logic              rv_q, rv_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= LOAD;
            shadow_q <= '0;
            cnt_q    <= '0;
            s_q      <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            pi_q     <= '0;
            settle_q <= '0;
            res_q    <= '0;
            rv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            s_q      <= s_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            pi_q     <= pi_d;
            settle_q <= settle_d;
            res_q    <= res_d;
            rv_q     <= rv_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        cnt_d     = cnt_q;
        s_d       = s_q;
        locked_d  = locked_q;
        err_d     = err_q;
        pi_d      = pi_q;
        settle_d  = settle_q;
        res_d     = res_q;
        rv_d      = rv_q;
        // key_ready drops once the parity beat is in; CHECK follows on the next edge
        key_ready = (state_q == LOAD) && (cnt_q != LAST_BEAT);
        vec_ready = (state_q == READY);

        case (state_q)
            LOAD: begin
                if (cnt_q == LAST_BEAT) begin
                    state_d = CHECK;
                end else if (key_valid) begin
                    shadow_d = {shadow_q[KEY_W-1:0], key_bit};
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == '0) err_d = 1'b0;
                end
            end
            CHECK: begin
                if (^shadow_q == 1'b0) begin
                    s_d      = shadow_q[KEY_W:1];
                    locked_d = 1'b1;
                    state_d  = READY;
                end else begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = LOAD;
                end
            end
            READY: begin
                if (vec_valid) begin
                    pi_d     = vec_in;
                    settle_d = SETTLE_LOAD;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_q == '0) begin
                    res_d   = po_in;
                    rv_d    = 1'b1;
                    state_d = HOLD;
                end else begin
                    settle_d = settle_q - 8'd1;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    rv_d    = 1'b0;
                    state_d = READY;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    assign key_locked = locked_q;
    assign key_err    = err_q;
    assign s_out      = s_q;
    assign pi_out     = pi_q;
    assign res_out    = res_q;
    assign res_valid  = rv_q;

endmodule

// File: tb/tb_camo_key_loader.sv
// Randomized scoreboard bench for camo_key_loader: driver pushes expected
// results, an independent monitor checks them whenever res_valid is up.
module tb_camo_key_loader;

    localparam int unsigned KEY_W  = 12;
    localparam int unsigned PI_W   = 36;
    localparam int unsigned PO_W   = 7;
    localparam int unsigned SETTLE = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              key_bit = 1'b0;
    logic              key_valid = 1'b0;
    logic              key_ready;
    logic              key_locked;
    logic              key_err;
    logic [KEY_W-1:0]  s_out;
    logic [PI_W-1:0]   vec_in = '0;
    logic              vec_valid = 1'b0;
    logic              vec_ready;
    logic [PI_W-1:0]   pi_out;
    logic [PO_W-1:0]   po_in = '0;
    logic [PO_W-1:0]   res_out;
    logic              res_valid;
    logic              res_ready = 1'b0;

    camo_key_loader #(
        .NUM_CELLS(6), .KEY_W(KEY_W), .PI_W(PI_W), .PO_W(PO_W), .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk(clk), .rst(rst), .key_bit(key_bit), .key_valid(key_valid),
        .key_ready(key_ready), .key_locked(key_locked), .key_err(key_err),
        .s_out(s_out), .vec_in(vec_in), .vec_valid(vec_valid), .vec_ready(vec_ready),
        .pi_out(pi_out), .po_in(po_in), .res_out(res_out), .res_valid(res_valid),
        .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PO_W-1:0] po;
        logic [PI_W-1:0] pi;
        int              t_acc;
    } exp_t;

    exp_t            sb[$];
    int              cyc = 0;
    int              n_pass = 0;
    int              n_total = 0;
    logic [KEY_W-1:0] exp_s = '0;
    logic            exp_err = 1'b0;
    logic            rv_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        else n_pass++;
    endtask

    // Monitor: every cycle with res_valid up must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst) begin
            rv_prev <= 1'b0;
        end else begin
            if (res_valid) begin
                if (sb.size() == 0) begin
                    chk("res_valid_unexpected", 64'(res_valid), 64'd0);
                end else begin
                    if (!rv_prev) chk("latency", 64'(cyc - sb[0].t_acc), 64'(SETTLE));
                    chk("res_out", 64'(res_out), 64'(sb[0].po));
                    chk("pi_out", 64'(pi_out), 64'(sb[0].pi));
                    chk("vec_ready_in_hold", 64'(vec_ready), 64'd0);
                    if (res_ready) void'(sb.pop_front());
                end
            end
            rv_prev <= res_valid;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        key_valid = 1'b0; vec_valid = 1'b0; res_ready = 1'b0;
        #1;
        exp_s = '0; exp_err = 1'b0;
        chk("rst_key_ready", 64'(key_ready), 64'd1);
        chk("rst_key_locked", 64'(key_locked), 64'd0);
        chk("rst_key_err", 64'(key_err), 64'd0);
        chk("rst_s_out", 64'(s_out), 64'd0);
        chk("rst_vec_ready", 64'(vec_ready), 64'd0);
        chk("rst_pi_out", 64'(pi_out), 64'd0);
        chk("rst_res_out", 64'(res_out), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Serially shifts key (MSB first) then the parity bit; pass iff total parity even.
    task automatic load_key(input logic [KEY_W-1:0] key, input logic par, output logic pass);
        logic [KEY_W:0] word;
        word = {key, par};
        pass = (^word == 1'b0);
        for (int i = KEY_W; i >= 0; i--) begin
            key_valid = 1'b1;
            key_bit = word[i];
            chk("key_ready_shift", 64'(key_ready), 64'd1);
            @(posedge clk); #1;
            chk("s_out_during_shift", 64'(s_out), 64'(exp_s));
            if (i == KEY_W) begin
                exp_err = 1'b0;
                chk("key_err_first_beat", 64'(key_err), 64'd0);
            end
        end
        key_valid = 1'b0;
        chk("key_ready_after_parity", 64'(key_ready), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        if (pass) exp_s = key;
        exp_err = !pass;
        chk("key_locked", 64'(key_locked), 64'(pass));
        chk("key_err", 64'(key_err), 64'(exp_err));
        chk("s_out_after_check", 64'(s_out), 64'(exp_s));
        chk("key_ready_after_check", 64'(key_ready), 64'(!pass));
    endtask

    task automatic send_vec(input logic [PI_W-1:0] pi, input logic [PO_W-1:0] po,
                            input int unsigned hold, input logic abort);
        int unsigned n = 0;
        exp_t e;
        vec_in = pi; vec_valid = 1'b1; po_in = po;
        while (!vec_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!vec_ready) begin
            chk("vec_accept_timeout", 64'(vec_ready), 64'd1);
            vec_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        vec_valid = 1'b0;
        vec_in = PI_W'({$urandom, $urandom});
        e.po = po; e.pi = pi; e.t_acc = cyc;
        sb.push_back(e);
        if (abort) begin
            repeat (2) @(posedge clk);
            #1;
            void'(sb.pop_back());
            do_reset();
            repeat (8) @(posedge clk);
            #1;
            chk("res_valid_after_abort", 64'(res_valid), 64'd0);
            chk("key_ready_after_abort", 64'(key_ready), 64'd1);
            return;
        end
        repeat (SETTLE) @(posedge clk);
        #1;
        for (int unsigned h = 0; h < hold; h++) begin
            po_in = PO_W'($urandom);
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("vec_ready_after_hs", 64'(vec_ready), 64'd1);
        chk("res_valid_after_hs", 64'(res_valid), 64'd0);
        chk("pi_out_held", 64'(pi_out), 64'(pi));
    endtask

    initial begin
        logic ok;
        logic [KEY_W-1:0] k;
        logic p;
        do_reset();

        load_key(12'hA5C, 1'b1, ok);
        load_key(12'hA5C, 1'b0, ok);

        send_vec(36'h0_0000_0001, 7'h5A, 10, 1'b0);

        for (int i = 0; i < 20; i++) begin
            key_valid = 1'b1;
            key_bit = 1'($urandom);
            @(posedge clk); #1;
            chk("locked_key_ready", 64'(key_ready), 64'd0);
            chk("locked_s_out", 64'(s_out), 64'(exp_s));
        end
        key_valid = 1'b0;

        for (int i = 0; i < 12; i++)
            send_vec(PI_W'({$urandom, $urandom}), PO_W'($urandom), $urandom_range(0, 3), 1'b0);

        send_vec(PI_W'({$urandom, $urandom}), PO_W'($urandom), 0, 1'b1);

        for (int i = 0; i < 7; i++) begin
            key_valid = 1'b1;
            key_bit = 1'($urandom);
            @(posedge clk); #1;
        end
        key_valid = 1'b0;
        do_reset();

        for (int r = 0; r < 4; r++) begin
            k = KEY_W'($urandom);
            p = 1'($urandom);
            load_key(k, p, ok);
            if (!ok) load_key(k, ^k, ok);
            for (int i = 0; i < 3; i++)
                send_vec(PI_W'({$urandom, $urandom}), PO_W'($urandom), $urandom_range(0, 2), 1'b0);
            if (r != 3) do_reset();
        end

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
